// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: one-byte holding register in front of a shift-register FSM.
// Latency: a data write in cycle n drives the tx start bit from the edge ending cycle n+2.
// Backpressure: none; writes while the holding register is full are dropped and set a sticky overrun flag.
module uart_tx_mmio #(
    parameter int          CLK_HZ = 100000000,
    parameter int          BAUD   = 115200,
    parameter logic [15:0] TX_A   = 16'd8194
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        writeM,
    input  logic [15:0] addressW,
    input  logic [15:0] inM,
    input  logic [15:0] addressR,
    output logic [15:0] rdata,
    output logic        tx
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    hold;
    logic          full;
    logic          overrun;
    logic          wr_sel;
    logic          bit_end;

    assign wr_sel  = writeM && (addressW == TX_A);
    assign bit_end = (baud_cnt == LAST);

    // Status word: full in bit 15 so a busy transmitter reads as negative.
    assign rdata = (addressR == TX_A) ? {full, overrun, 14'b0} : 16'h0000;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            hold     <= 8'h00;
            full     <= 1'b0;
            overrun  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            // full is the pre-edge value here, so a write racing a transfer is dropped.
            if (wr_sel) begin
                if (inM[15]) begin
                    overrun <= 1'b0;
                end else if (full) begin
                    overrun <= 1'b1;
                end else begin
                    hold <= inM[7:0];
                    full <= 1'b1;
                end
            end

            // tx reflects the state of the cycle just ending, one cycle behind state.
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (full) begin
                        shreg    <= hold;
                        full     <= 1'b0;
                        state    <= START;
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx <= shreg[bit_idx];
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
